// File: rtl/work_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : work_packet_tx
//  Purpose  : UART 8N1 transmitter for a 64-byte Icarus-format work packet.
//             A start pulse in IDLE latches {midstate, data2}. The payload is
//             then sent MSB byte first, each byte LSB first, at CLOCK/BAUD.
//             GAP_BITS idle bit periods are inserted between bytes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1    clock for all logic
//    rst_n     in   1    asynchronous active-low reset
//    start     in   1    one-cycle send request; honoured only in IDLE
//    abort     in   1    cancels the packet in flight (synchronous)
//    midstate  in   256  payload bytes 0..31
//    data2     in   256  payload bytes 32..63
//    tx        out  1    serial line, idle high, registered
//    busy      out  1    packet in flight
//    done      out  1    one-cycle pulse on normal completion
//    byte_idx  out  6    index of the byte currently on the line
// ============================================================================
module work_packet_tx #(
    parameter int CLOCK    = 25000000,
    parameter int BAUD     = 115200,
    parameter int GAP_BITS = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [5:0]   byte_idx
);

    localparam int DIV = CLOCK / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int GW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [CW-1:0] BIT_RELOAD = CW'(DIV - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t         state,      state_next;
    logic [CW-1:0]  bit_cnt,    bit_cnt_next;
    logic [2:0]     bit_idx,    bit_idx_next;
    logic [GW-1:0]  gap_cnt,    gap_cnt_next;
    logic [5:0]     byte_cnt,   byte_cnt_next;
    logic [511:0]   shreg,      shreg_next;
    logic           tx_q,       tx_next;
    logic           done_q,     done_next;
    logic [7:0]     cur_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            bit_idx  <= bit_idx_next;
            gap_cnt  <= gap_cnt_next;
            byte_cnt <= byte_cnt_next;
            shreg    <= shreg_next;
            tx_q     <= tx_next;
            done_q   <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        bit_idx_next  = bit_idx;
        gap_cnt_next  = gap_cnt;
        byte_cnt_next = byte_cnt;
        shreg_next    = shreg;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                byte_cnt_next = '0;
                if (start && !abort) begin
                    shreg_next   = {midstate, data2};
                    state_next   = START;
                    bit_cnt_next = BIT_RELOAD;
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    state_next   = DATA;
                    bit_cnt_next = BIT_RELOAD;
                    bit_idx_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_next = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == '0) begin
                    if (byte_cnt == 6'd63) begin
                        state_next    = IDLE;
                        byte_cnt_next = '0;
                        done_next     = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        state_next   = GAP;
                        bit_cnt_next = BIT_RELOAD;
                        gap_cnt_next = GAP_RELOAD;
                    end else begin
                        // Next byte moves to the top of the shift register.
                        state_next    = START;
                        bit_cnt_next  = BIT_RELOAD;
                        byte_cnt_next = byte_cnt + 1'b1;
                        shreg_next    = {shreg[503:0], 8'h00};
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            GAP: begin
                if (bit_cnt == '0) begin
                    bit_cnt_next = BIT_RELOAD;
                    if (gap_cnt == '0) begin
                        state_next    = START;
                        byte_cnt_next = byte_cnt + 1'b1;
                        shreg_next    = {shreg[503:0], 8'h00};
                    end else begin
                        gap_cnt_next = gap_cnt - 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                byte_cnt_next = '0;
            end
        endcase

        // Abort drops the packet outright; the receiver times out on the
        // truncated byte.
        if (abort && (state != IDLE)) begin
            state_next    = IDLE;
            byte_cnt_next = '0;
            bit_cnt_next  = '0;
            bit_idx_next  = '0;
            gap_cnt_next  = '0;
            done_next     = 1'b0;
        end
    end

    // The line level is computed from the next state so that tx changes on
    // the same edge as the state it belongs to, while still coming from a flop.
    assign cur_byte = shreg_next[511:504];

    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign byte_idx = byte_cnt;

endmodule
`default_nettype wire
